ws2812_multi_fader: RTL

WS2812_MULTI_FADER -- requirements
Module: ws2812_multi_fader

---
 rtl/ws2812_multi_fader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ws2812_multi_fader.sv
// Scrolling colour fader for a WS2812 strip: random milestones are linearly
// interpolated across the LEDs and scaled by a global brightness.
module ws2812_multi_fader #(
  parameter int LEDS           = 32,
  parameter int CHANNELS       = 3,
  parameter int INTERPOLATIONS = 8,
  parameter int HOLDOFF_TIME   = 800000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5*CHANNELS-1:0]   random,
  input  logic                    data_request,
  input  logic [7:0]              brightness,
  input  logic                    reverse,
  input  logic                    pause,
  output logic                    trigger,
  output logic [7:0]              color_now,
  output logic                    frame_done
);

  localparam int MILESTONES = (LEDS + INTERPOLATIONS - 2) / INTERPOLATIONS + 2;
  localparam int LOG2I      = $clog2(INTERPOLATIONS);
  localparam int LW         = (LEDS > 1) ? $clog2(LEDS) : 1;
  localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int JW         = $clog2(MILESTONES);
  localparam int PW         = $clog2(LEDS + INTERPOLATIONS);
  localparam int SW         = 9 + LOG2I;
  localparam int CTW        = $clog2(HOLDOFF_TIME + 1);

  typedef enum logic {SEND = 1'b0, HOLDOFF = 1'b1} state_e;

  state_e                                 state_q, state_d;
  logic [MILESTONES-1:0][CHANNELS-1:0][7:0] m_q, m_d;
  logic [LOG2I-1:0]                       start_q, start_d;
  logic [LW-1:0]                          led_q, led_d;
  logic [CW-1:0]                          ch_q, ch_d;
  logic                                   rev_q, rev_d;
  logic [CTW-1:0]                         cnt_q, cnt_d;
  logic                                   fd_q, fd_d;

  logic              first_byte, rev_eff;
  logic [PW-1:0]     idx_w, p_w;
  logic [JW-1:0]     j_w, jn_w;
  logic [LOG2I-1:0]  k_w;
  logic [7:0]        raw_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEND;
      m_q     <= '0;
      start_q <= '0;
      led_q   <= '0;
      ch_q    <= '0;
      rev_q   <= 1'b0;
      cnt_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      start_q <= start_d;
      led_q   <= led_d;
      ch_q    <= ch_d;
      rev_q   <= rev_d;
      cnt_q   <= cnt_d;
      fd_q    <= fd_d;
    end
  end

  // The first byte of a frame already reflects the live reverse input, so the
  // value latched with it and the byte sent always agree.
  assign first_byte = (state_q == SEND) && (led_q == '0) && (ch_q == '0);
  assign rev_eff    = first_byte ? reverse : rev_q;

  assign idx_w = rev_eff ? (PW'(LEDS - 1) - PW'(led_q)) : PW'(led_q);
  assign p_w   = PW'(start_q) + idx_w;
  assign j_w   = JW'(p_w >> LOG2I);
  assign jn_w  = j_w + JW'(1);
  assign k_w   = p_w[LOG2I-1:0];

  assign raw_w = 8'(((SW'(m_q[j_w][ch_q]) * (SW'(INTERPOLATIONS) - SW'(k_w)))
                   + (SW'(m_q[jn_w][ch_q]) * SW'(k_w))) >> LOG2I);

  assign color_now  = 8'((17'(raw_w) * (17'(brightness) + 17'd1)) >> 8);
  assign trigger    = (state_q == SEND);
  assign frame_done = fd_q;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    start_d = start_q;
    led_d   = led_q;
    ch_d    = ch_q;
    rev_d   = rev_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
    case (state_q)
      SEND: begin
        if (first_byte) rev_d = reverse;
        if (data_request) begin
          if (ch_q == CW'(CHANNELS - 1)) begin
            ch_d = '0;
            if (led_q == LW'(LEDS - 1)) begin
              fd_d    = 1'b1;
              state_d = HOLDOFF;
              cnt_d   = CTW'(HOLDOFF_TIME);
              led_d   = '0;
              if (!pause) begin
                if (start_q != '0) begin
                  start_d = start_q - LOG2I'(1);
                end else begin
                  // Scroll by one milestone; the newest enters at index 0.
                  for (int i = MILESTONES - 1; i > 0; i--) m_d[i] = m_q[i-1];
                  for (int c = 0; c < CHANNELS; c++)
                    m_d[0][c] = {random[5*c +: 5], 3'b000};
                  start_d = LOG2I'(INTERPOLATIONS - 1);
                end
              end
            end else begin
              led_d = led_q + LW'(1);
            end
          end else begin
            ch_d = ch_q + CW'(1);
          end
        end
      end
      HOLDOFF: begin
        cnt_d = cnt_q - CTW'(1);
        if (cnt_q == CTW'(1)) state_d = SEND;
      end
      default: state_d = SEND;
    endcase
  end

endmodule
